// File: rtl/regfile_fwd_sb.sv
`default_nettype none
// ============================================================================
// Module   : regfile_fwd_sb
// Desc     : ID-stage register file with prioritised bypass, load-use and
//            pending-write hazard detection, and a saturating stall counter.
// Revision : 1.0
// ============================================================================
module regfile_fwd_sb #(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int NUM_RD   = 2,
    parameter int NUM_FWD  = 3,
    parameter int ZERO_REG = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_RD*AW-1:0]            raddr,
    input  logic [NUM_RD-1:0]               re,
    output logic [NUM_RD*DW-1:0]            rdata,
    input  logic [NUM_FWD*(DW+AW+2)-1:0]    fwd_bus,
    input  logic                            we,
    input  logic [AW-1:0]                   waddr,
    input  logic [DW-1:0]                   wdata,
    input  logic                            sb_set,
    input  logic [AW-1:0]                   sb_set_addr,
    input  logic                            sb_clr,
    input  logic [AW-1:0]                   sb_clr_addr,
    output logic [NUM_RD-1:0]               hazard,
    output logic                            stall,
    output logic [31:0]                     stall_cnt
);

    localparam int c_DEPTH = 2**AW;
    localparam int c_FW    = DW + AW + 2;

    logic [DW-1:0]      r_mem [c_DEPTH];
    logic [c_DEPTH-1:0] r_pending;
    logic [31:0]        r_stall_cnt;

    logic               w_wr_en;
    logic               w_sb_set_en;
    logic [NUM_FWD-1:0] w_fwd_rdy;
    logic [NUM_FWD-1:0] w_fwd_we;
    logic [AW-1:0]      w_fwd_addr [NUM_FWD];
    logic [DW-1:0]      w_fwd_data [NUM_FWD];

    assign w_wr_en     = we && !((ZERO_REG != 0) && (waddr == '0));
    assign w_sb_set_en = sb_set && !((ZERO_REG != 0) && (sb_set_addr == '0));

    // Entry layout, MSB to LSB: {ready, we, waddr, data}
    generate
        for (genvar i = 0; i < NUM_FWD; i++) begin : g_fwd
            assign w_fwd_data[i] = fwd_bus[i*c_FW +: DW];
            assign w_fwd_addr[i] = fwd_bus[i*c_FW + DW +: AW];
            assign w_fwd_we[i]   = fwd_bus[i*c_FW + DW + AW];
            assign w_fwd_rdy[i]  = fwd_bus[i*c_FW + DW + AW + 1];
        end
    endgenerate

    generate
        for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
            logic [AW-1:0] w_a;
            logic [DW-1:0] w_d;
            logic          w_h;
            logic          w_hit;

            assign w_a = raddr[p*AW +: AW];

            always_comb begin
                w_d   = r_mem[w_a];
                w_h   = re[p] && r_pending[w_a];
                w_hit = 1'b0;
                if ((ZERO_REG != 0) && (w_a == '0)) begin
                    w_d = '0;
                    w_h = 1'b0;
                end else begin
                    // Walk oldest to youngest so the youngest match is the one kept
                    for (int i = NUM_FWD - 1; i >= 0; i--) begin
                        if (w_fwd_we[i] && (w_fwd_addr[i] == w_a)) begin
                            w_hit = 1'b1;
                            w_d   = w_fwd_data[i];
                            w_h   = re[p] && !w_fwd_rdy[i];
                        end
                    end
                    if (!w_hit && we && (waddr == w_a)) begin
                        w_d = wdata;
                        w_h = 1'b0;
                    end
                end
            end

            assign rdata[p*DW +: DW] = w_d;
            assign hazard[p]         = w_h;
        end
    endgenerate

    assign stall     = |hazard;
    assign stall_cnt = r_stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < c_DEPTH; k++) begin
                r_mem[k] <= '0;
            end
        end else if (w_wr_en) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Set is applied after clear so a new producer wins on a same-address collision
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= '0;
        end else begin
            if (sb_clr) begin
                r_pending[sb_clr_addr] <= 1'b0;
            end
            if (w_sb_set_en) begin
                r_pending[sb_set_addr] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

endmodule
`default_nettype wire

// File: doc/regfile_fwd_sb.md
Name: regfile_fwd_sb

Overview:
- Parametrised successor to the single-write, two-read bypassing register file in the ID stage.
- Read-port count, data/address width and number of forwarding sources are parameters; forwarding sources are priority-ordered from youngest to oldest.
- Adds a per-ready bit on each forwarding source for load-use hazards.
- Adds a pending-write scoreboard for multi-cycle units (mul/div), a stall output and a saturating stall-cycle counter, so hazard detection lives next to the operand read.

Parameters:
- DW, 32, data width.
- AW, 5, register address width; depth is 2**AW.
- NUM_RD, 2, number of read ports.
- NUM_FWD, 3, number of forwarding sources; index 0 is youngest (EX), highest priority.
- ZERO_REG, 1, when 1 register 0 reads as zero and ignores writes and scoreboard sets.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- raddr  in  NUM_RD*AW  read addresses; port p uses bits [p*AW +: AW].
- re  in  NUM_RD  read enable per port; a port only raises a hazard when enabled.
- rdata  out  NUM_RD*DW  read data; port p uses bits [p*DW +: DW].
- fwd_bus  in  NUM_FWD*(DW+AW+2)  forwarding entries. Entry i is {ready, we, waddr[AW-1:0], data[DW-1:0]}, packed at [i*(DW+AW+2) +: DW+AW+2].
- we  in  1  write-port enable (WB commit).
- waddr  in  AW  write address.
- wdata  in  DW  write data.
- sb_set  in  1  mark sb_set_addr pending (long-latency op issued).
- sb_set_addr  in  AW  scoreboard set address.
- sb_clr  in  1  clear pending for sb_clr_addr (long-latency result committed).
- sb_clr_addr  in  AW  scoreboard clear address.
- hazard  out  NUM_RD  per-port hazard bitmap.
- stall  out  1  OR of hazard.
- stall_cnt  out  32  count of cycles with stall high.

Behaviour:

State and reset
- State is the register array (2**AW x DW), the pending vector (2**AW bits) and stall_cnt.
- rst high, asynchronously: all array entries are 0, all pending bits are 0, stall_cnt is 0. Consequently rdata reads 0 for every address, and hazard/stall are 0 unless fwd or scoreboard inputs drive them.
- Reset asserted mid-operation discards all state immediately; no write completes on that edge.

Array write (posedge)
- If we is high, array[waddr] <= wdata.
- Suppressed when ZERO_REG=1 and waddr==0.

Read (combinational, zero latency), per port p with address a, first rule that applies:
1. ZERO_REG=1 and a==0 -> data 0, no hazard.
2. Lowest index i with fwd_we[i] high and fwd_waddr[i]==a:
   - data = fwd_data[i];
   - hazard = re[p] && !fwd_ready[i].
   - Older matching entries are ignored even if ready.
3. No fwd match, but we high and waddr==a -> data = wdata (write-through), no hazard.
4. Otherwise -> data = array[a]; hazard = re[p] && pending[a].
- A ready fwd match or a write-through match overrides a set pending bit.

Scoreboard (posedge)
- If sb_clr is high, pending[sb_clr_addr] <= 0.
- If sb_set is high, pending[sb_set_addr] <= 1.
- If both are high with the same address, set wins (a new producer supersedes).
- sb_set to address 0 is ignored when ZERO_REG=1.
- Setting an already-pending bit or clearing a clear bit is harmless.

Stall and counter
- stall = |hazard, combinational.
- stall_cnt increments by 1 on each posedge where stall is high.
- stall_cnt saturates at 32'hFFFF_FFFF and does not wrap.

Width rules
- All address compares use the full AW bits.
- No arithmetic on data.

Test Plan:
- Reset, then read addr 5 on both ports -> rdata = 0, stall = 0. Write 0x1234 to r5, then next-cycle read -> 0x1234. Write 0xFFFF to r0 -> r0 reads 0.
- fwd0 = {1,1,r3,0xA}, fwd2 = {1,1,r3,0xC}, array r3 = 0xD -> read r3 returns 0xA. Drop fwd0.we -> returns 0xC. Drop fwd2.we -> returns 0xD.
- Load-use: fwd0 = {0,1,r7,x}, re[1]=1, raddr1=r7 -> hazard = 2'b10, stall = 1. With re[1]=0 -> stall = 0.
- Write-through: we=1, waddr=r9, wdata=0x55 with no fwd match -> read r9 = 0x55 in the same cycle.
- Scoreboard: sb_set r4, next cycle read r4 -> stall = 1. Present a fwd match {1,1,r4,0x77} -> data 0x77, stall = 0. Assert sb_clr r4 and sb_set r4 in the same cycle -> r4 stays pending. sb_clr alone -> stall drops the cycle after.
- Counter: hold a hazard for 10 cycles -> stall_cnt = 10. Assert rst asynchronously between edges -> stall_cnt, pending and array are 0 immediately. Force stall_cnt near max -> it saturates at 0xFFFFFFFF.
